// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU result collection path.
//   - Opcode constants: the highest implemented opcode is the op-8 halving unit.
//   - QNAN: the canonical quiet NaN substituted for results of unknown opcodes.
//   - Flag bit positions inside the 3-bit exception vector.
//   - pack_flags(): assembles {invalid_op, overflow, underflow} using those positions.
package fpu_pkg;

  localparam logic [3:0]  OP_RSHIFT = 4'd8;
  localparam logic [3:0]  OP_MAX    = OP_RSHIFT;   // highest implemented opcode
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;

  localparam int FLG_UNF = 0;
  localparam int FLG_OVF = 1;
  localparam int FLG_INV = 2;
  localparam int FLG_W   = 3;

  function automatic logic [FLG_W-1:0] pack_flags(input logic inv,
                                                  input logic ovf,
                                                  input logic unf);
    logic [FLG_W-1:0] f;
    f          = 3'b000;
    f[FLG_INV] = inv;
    f[FLG_OVF] = ovf;
    f[FLG_UNF] = unf;
    return f;
  endfunction

endpackage

// File: rtl/fpu_res_fifo.sv
// Generic synchronous FIFO with a registered head entry.
//   The head word (rd_data) always comes straight from a register, so there is no
//   combinational path from wr_data to rd_data; an entry written into an empty FIFO
//   appears on rd_data one cycle later. Writes are refused while full; reads are
//   ignored while empty. Simultaneous read+write keeps the count unchanged.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   wr_en, wr_data write request and data (accepted only when !full)
//   full           count == DEPTH
//   rd_en          consumer takes the head entry (effective only when rd_valid)
//   rd_data        registered head entry
//   rd_valid       registered, count != 0
module fpu_res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         rd_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic [W-1:0]  head_r, head_nxt_s;
  logic          valid_r;
  logic          push_s, pop_s;

  assign full     = (count_r == CNT_FULL);
  assign push_s   = wr_en && !full;
  assign pop_s    = rd_en && valid_r;
  assign rd_data  = head_r;
  assign rd_valid = valid_r;

  // Next pointer/count values and the next head word.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    head_nxt_s   = head_r;

    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase

    // The incoming word becomes the head when nothing older survives this edge;
    // otherwise the head is whichever stored entry the read pointer lands on.
    if (push_s && (count_r == (pop_s ? CNT_ONE : CNT_ZERO))) begin
      head_nxt_s = wr_data;
    end else if (count_nxt_s != CNT_ZERO) begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Control state and registered head; reset discards every buffered entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
      valid_r  <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      head_r   <= head_nxt_s;
      valid_r  <= (count_nxt_s != CNT_ZERO);
    end
  end

  // Storage array; contents are only meaningful below count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/fpu_result_stage.sv
// Collection stage behind the single-cycle FPU op units.
//   Checks the opcode, packs result + exception flags into one entry, buffers it in
//   fpu_res_fifo and presents the head to writeback with valid/ready. Sticky
//   exception flags OR-accumulate every pushed entry until flag_clr.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            producer handshake (in_ready low while full or rst)
//   in_op, in_result             opcode and selected unit result
//   in_underflow, in_overflow    unit exception flags
//   out_valid/out_ready          consumer handshake
//   out_op, out_result, out_flags  head entry, flags = {invalid_op, overflow, underflow}
//   flag_clr, sticky_flags       clear / read accumulated flags
module fpu_result_stage
  import fpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_underflow,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_op,
  output logic [WIDTH-1:0] out_result,
  output logic [FLG_W-1:0] out_flags,
  input  logic             flag_clr,
  output logic [FLG_W-1:0] sticky_flags
);

  localparam int EW = OP_W + WIDTH + FLG_W;

  logic             invalid_s;
  logic [WIDTH-1:0] res_s;
  logic [FLG_W-1:0] flags_s;
  logic [EW-1:0]    entry_s;
  logic [EW-1:0]    head_s;
  logic             full_s;
  logic             push_s;
  logic [FLG_W-1:0] sticky_r;

  // Opcode check: unknown opcodes store a quiet NaN and only the invalid flag.
  always_comb begin
    invalid_s = (in_op > OP_W'(OP_MAX));
    res_s     = in_result;
    flags_s   = 3'b000;
    if (invalid_s) begin
      res_s   = WIDTH'(QNAN);
      flags_s = pack_flags(1'b1, 1'b0, 1'b0);
    end else begin
      res_s   = in_result;
      flags_s = pack_flags(1'b0, in_overflow, in_underflow);
    end
  end

  assign entry_s  = {in_op, res_s, flags_s};
  assign in_ready = !full_s && !rst;
  assign push_s   = in_valid && in_ready;

  fpu_res_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push_s),
    .wr_data  (entry_s),
    .full     (full_s),
    .rd_en    (out_ready),
    .rd_data  (head_s),
    .rd_valid (out_valid)
  );

  assign {out_op, out_result, out_flags} = head_s;

  // Sticky flags: a flag raised by a same-cycle push survives flag_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_r <= 3'b000;
    end else if (push_s) begin
      sticky_r <= (flag_clr ? 3'b000 : sticky_r) | flags_s;
    end else if (flag_clr) begin
      sticky_r <= 3'b000;
    end else begin
      sticky_r <= sticky_r;
    end
  end

  assign sticky_flags = sticky_r;

endmodule

// File: tb/tb_fpu_result_stage.sv
module tb_fpu_result_stage;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_result;
  logic        in_underflow;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic        flag_clr;
  logic [2:0]  sticky_flags;

  int errors = 0;
  int checks = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  fpu_result_stage #(.WIDTH(32), .OP_W(4), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_result    (in_result),
    .in_underflow (in_underflow),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op       (out_op),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .flag_clr     (flag_clr),
    .sticky_flags (sticky_flags)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares each entry the consumer takes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h expected none", {out_op, out_result, out_flags});
      end else begin
        e = sb_q.pop_front();
        chk("out_entry", 64'({out_op, out_result, out_flags}), 64'(e));
      end
    end
  end

  // Offer one entry; called at posedge+1, returns at posedge+1 after acceptance.
  task automatic send(input logic [3:0] op, input logic [31:0] res,
                      input logic unf, input logic ovf,
                      input logic [31:0] eres, input logic [2:0] eflg);
    bit done;
    done         = 1'b0;
    in_valid     = 1'b1;
    in_op        = op;
    in_result    = res;
    in_underflow = unf;
    in_overflow  = ovf;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back({op, eres, eflg});
        done = 1'b1;
      end
      step();
    end
    in_valid     = 1'b0;
    in_op        = 'x;
    in_result    = 'x;
    in_underflow = 'x;
    in_overflow  = 'x;
    chk("send_accept", 64'(done), 64'd1);
  endtask

  // Let the consumer drain everything expected, then confirm the stage is empty.
  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_queue", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_op        = 4'd0;
    in_result    = 32'd0;
    in_underflow = 1'b0;
    in_overflow  = 1'b0;
    out_ready    = 1'b0;
    flag_clr     = 1'b0;

    // 1. reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_sticky", 64'(sticky_flags), 64'd0);
    chk("post_rst_out", 64'({out_op, out_result, out_flags}), 64'd0);
    step();

    // 2. single entry, one-cycle latency
    out_ready = 1'b1;
    send(4'd8, 32'h3F00_0000, 1'b0, 1'b0, 32'h3F00_0000, 3'b000);
    @(negedge clk);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    step();
    drain();

    // 3. fill with consumer stalled; third entry refused; in-order release
    out_ready    = 1'b0;
    in_valid     = 1'b1;
    in_op        = 4'd1;
    in_result    = 32'h1111_1111;
    in_underflow = 1'b0;
    in_overflow  = 1'b0;
    @(negedge clk);
    chk("fill1_in_ready", 64'(in_ready), 64'd1);
    if (in_ready) sb_q.push_back({4'd1, 32'h1111_1111, 3'b000});
    step();
    in_op     = 4'd2;
    in_result = 32'h2222_2222;
    @(negedge clk);
    chk("fill2_in_ready", 64'(in_ready), 64'd1);
    chk("fill2_head", 64'(out_result), 64'h1111_1111);
    if (in_ready) sb_q.push_back({4'd2, 32'h2222_2222, 3'b000});
    step();
    in_op     = 4'd3;
    in_result = 32'h3333_3333;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_head_hold", 64'({out_op, out_result}), 64'({4'd1, 32'h1111_1111}));
      step();
    end
    in_valid = 1'b0;
    drain();

    // 4. underflow flag and sticky behaviour
    send(4'd8, 32'h8000_0001, 1'b1, 1'b0, 32'h8000_0001, 3'b001);
    @(negedge clk);
    chk("sticky_unf", 64'(sticky_flags), 64'd1);
    repeat (3) @(negedge clk);
    chk("sticky_unf_hold", 64'(sticky_flags), 64'd1);
    step();
    flag_clr = 1'b1;
    send(4'd8, 32'h8000_0001, 1'b1, 1'b0, 32'h8000_0001, 3'b001);
    flag_clr = 1'b0;
    @(negedge clk);
    chk("sticky_clr_vs_push", 64'(sticky_flags), 64'd1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", 64'(sticky_flags), 64'd0);
    step();
    drain();

    // 5. illegal opcodes and overflow
    send(4'd12, 32'h1234_5678, 1'b0, 1'b1, 32'h7FC0_0000, 3'b100);
    @(negedge clk);
    chk("sticky_inv_only", 64'(sticky_flags), 64'b100);
    step();
    send(4'd9, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h7FC0_0000, 3'b100);
    send(4'd3, 32'h3FC0_0000, 1'b0, 1'b1, 32'h3FC0_0000, 3'b010);
    @(negedge clk);
    chk("sticky_inv_ovf", 64'(sticky_flags), 64'b110);
    step();
    send(4'd0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 3'b011);
    drain();

    // 6. steady push+pop at count=1, then reset mid-stream
    out_ready = 1'b0;
    send(4'd8, 32'hA000_0000, 1'b0, 1'b0, 32'hA000_0000, 3'b000);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [3:0]  op_v;
      logic [31:0] res_v;
      logic        unf_v;
      op_v         = 4'(i % 9);
      res_v        = 32'h1000_0000 + 32'(i);
      unf_v        = (i % 2) == 1;
      in_op        = op_v;
      in_result    = res_v;
      in_underflow = unf_v;
      in_overflow  = 1'b0;
      @(negedge clk);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      chk("stream_out_valid", 64'(out_valid), 64'd1);
      if (in_ready) sb_q.push_back({op_v, res_v, {2'b00, unf_v}});
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    sb_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_result", 64'(out_result), 64'd0);
    chk("midrst_sticky", 64'(sticky_flags), 64'd0);
    step();

    chk("final_queue", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
